dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer in front of the data-memory bank (DMemBank).
//  Shares the single level-sensitive memread/memwrite port between the CPU
//  load/store path (port 0) and a DMA/debug path (port 1). Registers all memory
//  controls, holds them for MEM_LAT cycles, captures readdata, then returns a
//  one-cycle ack to the winner. Sits between the MEM stage and DMemBank.
// PARAMETERS
//  ADDR_W   32  address width, forwarded unmodified to the bank
//  DATA_W   32  data width
//  MEM_LAT  1   cycles memread/memwrite are held asserted (>=1)
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-high reset
//  req0/req1    in   1       request from CPU / DMA; held until ack
//  we0/we1      in   1       1 = write, 0 = read; stable while req high
//  addr0/addr1  in   ADDR_W  request address; stable while req high
//  wdata0/wdata1 in  DATA_W  write data; stable while req high
//  ack0/ack1    out  1       one-cycle completion pulse
//  rdata0/rdata1 out DATA_W  read result; valid with ack, held until next read
//  memread      out  1       to bank
//  memwrite     out  1       to bank
//  address      out  ADDR_W  to bank
//  writedata    out  DATA_W  to bank
//  readdata     in   DATA_W  from bank
//  busy         out  1       high in ACCESS and RESP
// BEHAVIOUR
//  Reset: state IDLE; ack0/1, memread, memwrite, busy = 0; address, writedata,
//   rdata0/1 = 0; last_grant = 1 (port 0 wins first); access counter = 0.
//  FSM IDLE -> ACCESS -> RESP -> IDLE; every output is registered.
//  IDLE: if no req, stay. Else pick winner, latch grant/we/addr/wdata;
//   next cycle ACCESS with memread = ~we, memwrite = we, counter = MEM_LAT-1.
//  ACCESS: controls stable for exactly MEM_LAT cycles; counter decrements.
//   On last ACCESS cycle (counter==0) on read: rdata[grant] <= readdata.
//   Next: RESP with memread = memwrite = 0.
//  RESP: ack[grant] = 1 for this cycle only; last_grant <= grant; next IDLE.
//  Latency: req high in IDLE cycle N -> ack in cycle N+MEM_LAT+1.
//   Peak throughput one access per MEM_LAT+2 cycles.
//  Requester drops req the cycle after ack or keeps it high with new
//   fields for a back-to-back request; reqs are sampled only in IDLE.
//  Losing requester waits; its req/fields must remain stable; no ack.
//  Changing fields of a granted request after grant has no effect (latched).
//  address/writedata retain last value outside ACCESS; only strobes drop.
//  rdata of the other port and on writes is never modified.
//  Reset mid-ACCESS/RESP: transaction abandoned, no ack issued, strobes drop
//   asynchronously; requester re-issues after reset.
//  One-hot guarantee: ack0 & ack1 == 0; memread & memwrite == 0 always.
// CONFIGURATION
//  DMEM_ARB_ROUND_ROBIN_EN defined: simultaneous reqs go to the port NOT in
//   last_grant; a single req always wins. Not defined: fixed priority,
//   port 0 (CPU) always wins simultaneous reqs; last_grant unused.
// TESTING
//  1 Read: MEM_LAT=1, bank word 5 = 50, req0 rd addr 5 -> memread 1 cycle,
//    ack0 2 cycles after req sampled, rdata0 = 50.
//  2 Write then read: req1 wr addr 3 wdata 0xDEAD -> memwrite 1 cycle, ack1;
//    then req1 rd addr 3 -> rdata1 = 0xDEAD, rdata0 unchanged.
//  3 Contention, macro off: req0+req1 in same cycle, held -> ack0 first, ack1
//    MEM_LAT+2 cycles later; repeat -> port 0 always first.
//  4 Contention, macro on: both held continuously -> acks alternate 0,1,0,1.
//  5 MEM_LAT=3: memread high exactly 3 cycles, ack at N+4, addr stable.
//  6 Reset asserted mid-ACCESS -> strobes 0 immediately, no ack, IDLE after.

Source files
------------

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Two-requester arbiter and sequencer in front of the data-memory bank.
// The CPU load/store path (port 0) and the DMA/debug path (port 1) share
// the bank's single level-sensitive memread/memwrite port. A granted
// request has its controls registered and held for MEM_LAT cycles. Read
// data is captured on the last access cycle, and the winner then gets a
// one-cycle ack. Every output is driven straight from a flop.
//
// Configuration macro:
//   DMEM_ARB_ROUND_ROBIN_EN  defined   : simultaneous requests go to the port
//                                        that did not win last time
//                            undefined : port 0 always wins a tie
//
// Parameters:
//   ADDR_W   address width, passed through to the bank unchanged
//   DATA_W   data width
//   MEM_LAT  cycles the memread/memwrite strobe stays asserted (>= 1)
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset
//   req0 / req1      request from CPU / DMA, held until ack
//   we0 / we1        1 = write, 0 = read
//   addr0 / addr1    request address
//   wdata0 / wdata1  write data
//   ack0 / ack1      one-cycle completion pulse
//   rdata0 / rdata1  read result, valid with ack, held until the next read
//   memread          read strobe to the bank
//   memwrite         write strobe to the bank
//   address          address to the bank
//   writedata        write data to the bank
//   readdata         read data from the bank
//   busy             high while a transaction is in ACCESS or RESP
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              memread,
    output logic              memwrite,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,
    output logic              busy
);

    // The counter only has to hold MEM_LAT-1. It is kept at least one bit
    // wide so that MEM_LAT = 1 still gives a legal vector.
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state, state_next;
    logic               grant, grant_next;
    logic [CNT_W-1:0]   count, count_next;
    logic               pick;

    logic               ack0_next, ack1_next;
    logic [DATA_W-1:0]  rdata0_next, rdata1_next;
    logic               memread_next, memwrite_next;
    logic [ADDR_W-1:0]  address_next;
    logic [DATA_W-1:0]  writedata_next;
    logic               busy_next;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic               last_grant, last_grant_next;
`endif

    // Winner selection. A lone request always wins. On a tie, the
    // round-robin build favours the port that was not served last; the
    // default build always favours the CPU port.
    always_comb begin
        pick = 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        if (req0 && req1) begin
            pick = ~last_grant;
        end else begin
            pick = req1 && !req0;
        end
`else
        pick = req1 && !req0;
`endif
    end

    // Next-state and next-output logic. Every output is computed here one
    // cycle early and then registered. In IDLE the winner's fields are
    // latched into the bank-facing registers, so later changes on the
    // request inputs have no effect. The ack is raised on the last ACCESS
    // cycle so that it appears, registered, during RESP. address and
    // writedata keep their value after the access; only the strobes drop.
    always_comb begin
        state_next     = state;
        grant_next     = grant;
        count_next     = count;
        ack0_next      = 1'b0;
        ack1_next      = 1'b0;
        rdata0_next    = rdata0;
        rdata1_next    = rdata1;
        memread_next   = memread;
        memwrite_next  = memwrite;
        address_next   = address;
        writedata_next = writedata;
        busy_next      = busy;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        last_grant_next = last_grant;
`endif

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant_next     = pick;
                    address_next   = pick ? addr1  : addr0;
                    writedata_next = pick ? wdata1 : wdata0;
                    memwrite_next  = pick ? we1    : we0;
                    memread_next   = pick ? ~we1   : ~we0;
                    count_next     = CNT_W'(MEM_LAT - 1);
                    busy_next      = 1'b1;
                    state_next     = ACCESS;
                end
            end

            ACCESS: begin
                if (count == '0) begin
                    if (memread) begin
                        if (grant) begin
                            rdata1_next = readdata;
                        end else begin
                            rdata0_next = readdata;
                        end
                    end
                    ack0_next     = ~grant;
                    ack1_next     = grant;
                    memread_next  = 1'b0;
                    memwrite_next = 1'b0;
                    state_next    = RESP;
                end else begin
                    count_next = count - 1'b1;
                end
            end

            RESP: begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                last_grant_next = grant;
`endif
                busy_next  = 1'b0;
                state_next = IDLE;
            end

            default: begin
                memread_next  = 1'b0;
                memwrite_next = 1'b0;
                busy_next     = 1'b0;
                state_next    = IDLE;
            end
        endcase
    end

    // State and output registers. Reset abandons any transaction in flight
    // and drops the strobes at once, without waiting for a clock edge.
    // last_grant resets to 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= 1'b0;
            count     <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            memread   <= 1'b0;
            memwrite  <= 1'b0;
            address   <= '0;
            writedata <= '0;
            busy      <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state     <= state_next;
            grant     <= grant_next;
            count     <= count_next;
            ack0      <= ack0_next;
            ack1      <= ack1_next;
            rdata0    <= rdata0_next;
            rdata1    <= rdata1_next;
            memread   <= memread_next;
            memwrite  <= memwrite_next;
            address   <= address_next;
            writedata <= writedata_next;
            busy      <= busy_next;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_grant <= last_grant_next;
`endif
        end
    end

endmodule
